load_store_unit: RTL
====================

# load_store_unit

Memory-stage initiator for the word-wide `data_memory`. It accepts one load or store request at a time from the pipeline and drives the memory's `MemWrite`/`MemRead`/`addr`/`write_data` side. Sub-word loads are aligned and extended. Because `data_memory` has no byte enables, sub-word stores are done as read-modify-write (RMW). It sits between the execute/memory pipeline register and `data_memory`.

## Interface
Parameters:
- `XLEN`, 32, data and byte-address width.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE; request accepted when `req_valid && req_ready`
- `req_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V funct3
  - loads: LB=000, LH=001, LW=010, LBU=100, LHU=101
  - stores: SB=000, SH=001, SW=010
- `req_addr`  in  XLEN  byte address
- `req_wdata`  in  XLEN  store data; low bits are used for SB/SH
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure
- `resp_rdata`  out  XLEN  extended load data; 0 for stores and errors
- `resp_err`  out  1  misaligned access or illegal funct3, valid with `resp_valid`
- `mem_read`  out  1  to `data_memory.MemRead`
- `mem_write`  out  1  to `data_memory.MemWrite`
- `mem_addr`  out  XLEN  word index, `{2'b00, addr[XLEN-1:2]}`
- `mem_wdata`  out  XLEN  to `data_memory.write_data`
- `mem_rdata`  in  XLEN  from `data_memory.read_data`; combinational, valid in the same cycle as `mem_read`

## Operation
States: IDLE, READ, RMW_RD, RMW_WR, WRITE, RESP.

Transitions from IDLE on acceptance. The address, funct3, wdata and byte offset `addr[1:0]` are latched.
- Error → RESP with `resp_err=1`, no memory access. Error cases:
  - LH/LHU/SH with `addr[0]=1`
  - LW/SW with `addr[1:0]≠0`
  - any other funct3
- Load → READ
- SW → WRITE
- SB/SH → RMW_RD

Per-state behaviour:
- READ: `mem_read=1`. `mem_rdata` is captured at the closing edge → RESP.
- WRITE: `mem_write=1`, `mem_wdata=req_wdata` → RESP.
- RMW_RD: `mem_read=1`, word captured → RMW_WR.
- RMW_WR: `mem_write=1`, `mem_wdata` = captured word with the target lane replaced → RESP.
  - SB replaces byte `addr[1:0]`.
  - SH replaces half `addr[1]`.
- RESP: `resp_valid=1` for exactly one cycle → IDLE.

Load extraction:
- Byte lane `addr[1:0]`, half lane `addr[1]`.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

Invariants:
- `mem_read` and `mem_write` are never high together.
- `mem_addr` is stable for every cycle either strobe is high.
- `mem_addr` and `mem_wdata` are 0 when both strobes are low.

## Timing
- Request accepted at edge t:
  - load: `mem_read` in cycle t+1, `resp_valid` in cycle t+2 (2-cycle latency)
  - SW: `mem_write` in cycle t+1, response in t+2
  - SB/SH: read in t+1, write in t+2, response in t+3
  - error: response in t+1
- `req_ready` is low from the cycle after acceptance until the cycle after the RESP cycle (back in IDLE). `req_valid` is ignored while `req_ready` is low.
- Reset values: state IDLE, `req_ready=1`, all other outputs 0. No request is accepted while `rst_n=0`.
- Reset asserted mid-operation:
  - `mem_read`/`mem_write` drop immediately (asynchronous).
  - The in-flight request is discarded with no `resp_valid`.
  - A partially done RMW leaves memory unmodified, since the write has not occurred before RMW_WR.

## Structure
- Shared package/header `riscv_pkg`:
  - funct3 load/store constants
  - the state encoding (3 bits)
  - `XLEN`
- One combinational sub-module, `lsu_align`:
  - inputs: funct3, offset, raw word, store data
  - outputs: extended load value, merged store word, misalign/illegal flag
- The FSM and latches stay in `load_store_unit`.

## Test plan
1. SW addr 0x0, wdata 0x0000ABCD → one-cycle `mem_write` with `mem_addr=0`, `mem_wdata=0x0000ABCD`; then `resp_valid`, `resp_err=0`.
2. LW addr 0x0, memory word 0x0000ABCD → `mem_read` at t+1, `resp_rdata=0x0000ABCD` at t+2.
3. SB addr 0x1, wdata 0x000000EF, memory word 0x0000ABCD → RMW writes 0x0000EFCD to word 0; `mem_read`/`mem_write` never overlap.
4. Word 0x8001EFCD at word index 0:
   - LB 0x1 → 0xFFFFFFEF
   - LBU 0x1 → 0x000000EF
   - LH 0x2 → 0xFFFF8001
   - LHU 0x2 → 0x00008001
5. LW addr 0x2; SH addr 0x3; funct3=011 → `resp_err=1`, `resp_rdata=0`, response at t+1, no memory strobe.
6. Drop `rst_n` during RMW_WR, and during a held `req_valid` → `mem_write` low immediately, no `resp_valid`, `req_ready=1` after release, next request serviced normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: data width, funct3 encodings
// for loads and stores, and the 3-bit controller state encoding.
package riscv_pkg;

   localparam int XLEN = 32;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_RMW_RD = 3'd2,
      S_RMW_WR = 3'd3,
      S_WRITE  = 3'd4,
      S_RESP   = 3'd5
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline request/response and data_memory signals.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// resp_valid is a one-cycle pulse with no backpressure; the memory side has
// no handshake (mem_rdata is combinational in the mem_read cycle).
interface load_store_unit_if;
   import riscv_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic            req_store;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            resp_valid;
   logic [XLEN-1:0] resp_rdata;
   logic            resp_err;
   logic            mem_read;
   logic            mem_write;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;

   // View of the load/store unit itself
   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_read, mem_write, mem_addr, mem_wdata
   );

   // View of the surrounding pipeline and memory
   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_read, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data, merges sub-word
// store data into a word, and flags illegal funct3 or misaligned addresses.
module lsu_align
   import riscv_pkg::*;
(
   input  logic            store_i,
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      offset_i,
   input  logic [XLEN-1:0] raw_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] load_o,
   output logic [XLEN-1:0] merged_o,
   output logic            err_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and half-word lanes out of the raw word
   always_comb begin
      byte_sel = raw_i[7:0];
      case (offset_i)
         2'd0:    byte_sel = raw_i[7:0];
         2'd1:    byte_sel = raw_i[15:8];
         2'd2:    byte_sel = raw_i[23:16];
         default: byte_sel = raw_i[31:24];
      endcase
      half_sel = offset_i[1] ? raw_i[31:16] : raw_i[15:0];
   end

   // Extend the selected lane according to the load type
   always_comb begin
      load_o = '0;
      case (funct3_i)
         F3_LB:   load_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LH:   load_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LW:   load_o = raw_i;
         F3_LBU:  load_o = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LHU:  load_o = {{(XLEN-16){1'b0}}, half_sel};
         default: load_o = '0;
      endcase
   end

   // Replace the target byte/half lane of the raw word with store data
   always_comb begin
      merged_o = raw_i;
      if (funct3_i == F3_SB) begin
         case (offset_i)
            2'd0:    merged_o[7:0]   = wdata_i[7:0];
            2'd1:    merged_o[15:8]  = wdata_i[7:0];
            2'd2:    merged_o[23:16] = wdata_i[7:0];
            default: merged_o[31:24] = wdata_i[7:0];
         endcase
      end else if (funct3_i == F3_SH) begin
         if (offset_i[1]) merged_o[31:16] = wdata_i[15:0];
         else             merged_o[15:0]  = wdata_i[15:0];
      end else begin
         merged_o = wdata_i;
      end
   end

   // Illegal funct3 for the access direction, or address not size-aligned
   always_comb begin
      err_o = 1'b1;
      case (funct3_i)
         3'b000:        err_o = 1'b0;
         3'b001:        err_o = offset_i[0];
         3'b010:        err_o = |offset_i;
         F3_LBU:        err_o = store_i;
         F3_LHU:        err_o = store_i | offset_i[0];
         default:       err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage initiator: one load/store at a time towards a word-wide memory
// without byte enables; sub-word stores are done as read-modify-write.
module load_store_unit
   import riscv_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   load_store_unit_if.slave   bus,
   output lsu_state_e         state_o
);

   lsu_state_e      state_q, state_d;
   logic [XLEN-1:0] addr_q;
   logic [2:0]      funct3_q;
   logic            store_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] word_q;
   logic [XLEN-1:0] rdata_q;
   logic            err_q;

   logic            idle;
   logic            accept;
   logic            al_store;
   logic [2:0]      al_funct3;
   logic [1:0]      al_offset;
   logic [XLEN-1:0] al_raw;
   logic [XLEN-1:0] al_load;
   logic [XLEN-1:0] al_merged;
   logic            al_err;

   assign idle    = (state_q == S_IDLE);
   assign accept  = idle && bus.req_valid;
   assign state_o = state_q;

   // In IDLE the aligner classifies the incoming request; afterwards it works
   // on the latched request. The raw word is the captured word only while
   // merging, otherwise the live memory read data.
   assign al_store  = idle ? bus.req_store      : store_q;
   assign al_funct3 = idle ? bus.req_funct3     : funct3_q;
   assign al_offset = idle ? bus.req_addr[1:0]  : addr_q[1:0];
   assign al_raw    = (state_q == S_RMW_WR) ? word_q : bus.mem_rdata;

   lsu_align u_align (
      .store_i  (al_store),
      .funct3_i (al_funct3),
      .offset_i (al_offset),
      .raw_i    (al_raw),
      .wdata_i  (wdata_q),
      .load_o   (al_load),
      .merged_o (al_merged),
      .err_o    (al_err)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (al_err)                        state_d = S_RESP;
               else if (!bus.req_store)           state_d = S_READ;
               else if (bus.req_funct3 == F3_SW)  state_d = S_WRITE;
               else                               state_d = S_RMW_RD;
            end
         end
         S_READ:   state_d = S_RESP;
         S_RMW_RD: state_d = S_RMW_WR;
         S_RMW_WR: state_d = S_RESP;
         S_WRITE:  state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Request latches and captured memory data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         funct3_q <= '0;
         store_q  <= 1'b0;
         wdata_q  <= '0;
         word_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            addr_q   <= bus.req_addr;
            funct3_q <= bus.req_funct3;
            store_q  <= bus.req_store;
            wdata_q  <= bus.req_wdata;
            err_q    <= al_err;
            rdata_q  <= '0;
         end
         if (state_q == S_READ)   rdata_q <= al_load;
         if (state_q == S_RMW_RD) word_q  <= bus.mem_rdata;
      end
   end

   // Outputs decoded from state; address/data held at 0 when no strobe
   always_comb begin
      bus.req_ready  = idle;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = '0;
      bus.resp_err   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      case (state_q)
         S_READ, S_RMW_RD: begin
            bus.mem_read = 1'b1;
            bus.mem_addr = {2'b00, addr_q[XLEN-1:2]};
         end
         S_WRITE: begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = {2'b00, addr_q[XLEN-1:2]};
            bus.mem_wdata = wdata_q;
         end
         S_RMW_WR: begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = {2'b00, addr_q[XLEN-1:2]};
            bus.mem_wdata = al_merged;
         end
         S_RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = err_q;
            bus.resp_rdata = err_q ? '0 : rdata_q;
         end
         default: ;
      endcase
   end

endmodule
